pipeline_skid_stage: RTL
========================

Name: pipeline_skid_stage

Overview:
Parametrised, elastic IF/ID pipeline stage register carrying PC+4 and instruction from Fetch to Decode. It replaces a plain enable-gated register with a valid/ready handshake, a one-entry skid buffer for full throughput under back-pressure, and a synchronous flush that injects a bubble. It sits between the fetch unit and the decode stage, and can be reused for later stage boundaries.

Parameters:
WIDTH, 32, width of the PC+4 and instruction fields
NOP_INSTR, 32'h00000000, instruction value loaded on reset/flush (MIPS sll $0,$0,0)
CNT_W, 16, width of stall counter (used only with optional feature)

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Flush  input  1  synchronous squash of all held entries (branch/jump redirect)
in_valid  input  1  fetch presents valid PC+4/instruction
in_ready  output  1  stage can accept this cycle
in_pc_plus4  input  WIDTH  PCPlus4F
in_instr  input  WIDTH  InstructionF
out_valid  output  1  decode-side entry valid
out_ready  input  1  decode consumes this cycle (de-asserted on hazard stall)
out_pc_plus4  output  WIDTH  PCPlus4D
out_instr  output  WIDTH  InstructionD

Behaviour:
- Storage: main register (main_v, main_pc, main_ins) drives outputs directly; skid register (skid_v, skid_pc, skid_ins) is internal.
- out_valid = main_v; out_pc_plus4/out_instr = main_pc/main_ins; in_ready = ~skid_v (registered, no combinational path from out_ready).
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- States: EMPTY (main_v=0, skid_v=0), ONE (1,0), TWO (1,1). main_v=0 with skid_v=1 is illegal and never reached.
- EMPTY: accept -> main<=in, go ONE; else hold.
- ONE: accept&drain -> main<=in, stay ONE; accept&~drain -> skid<=in, go TWO; ~accept&drain -> go EMPTY (data regs keep stale values); neither -> hold.
- TWO: in_ready=0, so no accept. drain -> main<=skid, skid_v<=0, go ONE; else hold all.
- Latency: accept at edge N -> out_valid high after edge N. Throughput is 1 instruction/cycle while out_ready is held high.
- Ordering: strictly FIFO; no entry is dropped or duplicated except by flush/reset.
- Flush (priority over all transfers): next edge main_v<=0, skid_v<=0, main_ins<=NOP_INSTR, main_pc<=0. Any accept in the same cycle is consumed and discarded (fetch must not re-present it). A drain in the same cycle still counts as consumed by decode.
- Reset (priority over Flush): same as flush, and in_ready=1 after the edge.
- Reset values: out_valid=0, out_instr=NOP_INSTR, out_pc_plus4=0, in_ready=1, skid regs 0.
- Data outputs are defined only when out_valid=1. Outside reset/flush, they are stable while out_valid=1 and out_ready=0.
- Reset or Flush asserted mid-stall (TWO state): both entries are lost and the stage returns to EMPTY in one cycle.

Optional Feature:
Macro PIPE_STAGE_STALL_CNT_EN.
- Defined: adds output port stall_count [CNT_W-1:0]. It increments each cycle that out_valid=1 and out_ready=0, and saturates at all-ones (no wrap). Reset clears it to 0; Flush does not affect it.
- Undefined: the port and counter logic are absent, and all other behaviour is identical.

Test Plan:
- Reset: hold Reset 2 cycles with in_valid=1 -> out_valid=0, out_instr=0x00000000, out_pc_plus4=0, in_ready=1 after release.
- Streaming: out_ready=1; present instrs 0x20080001,0x20090002,0x200A0003 with PC+4 0x4,0x8,0xC on consecutive cycles -> appear on outputs in same order, one cycle later each, out_valid continuous.
- Back-pressure: with 0x20080001 in main, drop out_ready and present 0x20090002 -> accepted into skid, in_ready=0 next cycle; fetch holds 0x200A0003 for 3 cycles, no change on outputs; raise out_ready -> 0x20090002 then 0x200A0003 emerge, none lost.
- Flush in TWO state: main=0x1, skid=0x2, assert Flush with in_valid=1 (instr 0x3) -> next cycle out_valid=0, out_instr=NOP_INSTR, in_ready=1; 0x3 never appears on outputs.
- Simultaneous accept+drain in ONE state for 8 cycles -> skid never used, in_ready stays 1.
- With PIPE_STAGE_STALL_CNT_EN, CNT_W=4: stall 20 cycles -> stall_count saturates at 15; Flush leaves it at 15; Reset clears it to 0.

Source files
------------

// File: rtl/pipeline_skid_stage.sv
// Elastic IF/ID stage: valid/ready handshake with a one-entry skid buffer and synchronous flush.
// Optional saturating stall counter on output stall_count when PIPE_STAGE_STALL_CNT_EN is defined.
module pipeline_skid_stage #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h00000000,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc_plus4,
  input  logic [WIDTH-1:0] in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc_plus4,
  output logic [WIDTH-1:0] out_instr
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  // Encoding chosen so bit0 is main_v and bit1 is skid_v.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b11
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_main_pc;
  logic [WIDTH-1:0] r_main_ins;
  logic [WIDTH-1:0] r_skid_pc;
  logic [WIDTH-1:0] r_skid_ins;

  logic w_main_v;
  logic w_skid_v;
  logic w_accept;
  logic w_drain;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  assign w_main_v = r_state[0];
  assign w_skid_v = r_state[1];
  assign w_accept = in_valid & in_ready;
  assign w_drain  = w_main_v & out_ready;

  assign in_ready     = ~w_skid_v;
  assign out_valid    = w_main_v;
  assign out_pc_plus4 = r_main_pc;
  assign out_instr    = r_main_ins;

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_load_main_in = 1'b1;
          w_state_next   = S_ONE;
        end
      end
      S_ONE: begin
        if (w_accept && w_drain) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_load_skid  = 1'b1;
          w_state_next = S_TWO;
        end else if (w_drain) begin
          w_state_next = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_drain) begin
          w_load_main_skid = 1'b1;
          w_state_next     = S_ONE;
        end
      end
      default: begin
        w_state_next = S_EMPTY;
      end
    endcase
  end

  // Data registers keep stale contents when emptied; only valid bits matter downstream.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_main_pc  <= '0;
      r_main_ins <= NOP_INSTR;
      r_skid_pc  <= '0;
      r_skid_ins <= '0;
    end else if (Flush) begin
      r_main_pc  <= '0;
      r_main_ins <= NOP_INSTR;
    end else begin
      if (w_load_main_in) begin
        r_main_pc  <= in_pc_plus4;
        r_main_ins <= in_instr;
      end else if (w_load_main_skid) begin
        r_main_pc  <= r_skid_pc;
        r_main_ins <= r_skid_ins;
      end
      if (w_load_skid) begin
        r_skid_pc  <= in_pc_plus4;
        r_skid_ins <= in_instr;
      end
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Counts cycles an entry is held back by decode; flush leaves it untouched.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cnt <= '0;
    end else if (w_main_v && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule
